// File: rtl/fetch_align_buffer.sv
// Halfword re-alignment buffer between fetch and decode: assembles 16/32-bit
// instructions from word-aligned fetches, expands RVC encodings, handles redirects.
module fetch_align_buffer #(
  parameter int unsigned HW_DEPTH     = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  input  logic        fetch_err_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        is_compressed_o,
  output logic        illegal_o,
  output logic        fetch_err_o
);

  localparam int unsigned PTR_W = $clog2(HW_DEPTH);
  localparam int unsigned CNT_W = $clog2(HW_DEPTH + 1);
  localparam int unsigned ENT_W = 17;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef enum logic [1:0] {ST_RUN, ST_SKIP, ST_ERR} state_e;

  logic [ENT_W-1:0] buf_q [HW_DEPTH];
  logic [ENT_W-1:0] buf_d [HW_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_nxt;
  logic [CNT_W-1:0] count_q, count_d, push_n, pop_n;
  logic [31:0]      pc_q, pc_d;
  state_e           state_q, state_d;

  logic [ENT_W-1:0] h0, h1;
  logic [15:0]      c;
  logic [4:0]       rs1p, rs2p;
  logic [31:0]      dec_instr;
  logic             dec_ill, comp, has1, has2, valid, err, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == HW_DEPTH - 32'd1) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_nxt = ptr_inc(rd_ptr_q);
  assign h0     = buf_q[rd_ptr_q];
  assign h1     = buf_q[rd_nxt];
  assign c      = h0[15:0];
  assign rs1p   = {2'b01, c[9:7]};
  assign rs2p   = {2'b01, c[4:2]};

  assign comp  = (c[1:0] != 2'b11);
  assign has1  = (count_q != '0);
  assign has2  = (count_q >= CNT_W'(2));
  assign valid = (state_q != ST_ERR) && ((has1 && (comp || h0[16])) || has2);
  assign err   = h0[16] | (!comp && has2 && h1[16]);
  assign push  = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop   = valid && instr_ready_i && !flush_i;

  // Ready depends only on registered state so the fetch handshake cannot loop.
  assign fetch_ready_o   = rst_ni && (count_q <= CNT_W'(HW_DEPTH - 2)) && (state_q != ST_ERR);
  assign instr_valid_o   = valid;
  assign instr_pc_o      = valid ? pc_q : '0;
  assign is_compressed_o = valid && comp;
  assign illegal_o       = valid && comp && dec_ill;
  assign fetch_err_o     = valid && err;
  // A faulted head drops the upper half so the output cannot shift under a stall.
  assign instr_o = !valid ? '0 : comp ? dec_instr : h0[16] ? {16'h0, c} : {h1[15:0], c};

  // RV32C expansion of the head halfword.
  always_comb begin
    dec_ill   = 1'b0;
    dec_instr = {16'h0, c};
    case ({c[1:0], c[15:13]})
      5'b00_000: begin
        dec_instr = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rs2p, OP_IMM};
        dec_ill   = (c[12:5] == 8'h0);
      end
      5'b00_010: dec_instr = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rs2p, OP_LOAD};
      5'b00_110: dec_instr = {5'b0, c[5], c[12], rs2p, rs1p, 3'b010, c[11:10], c[6], 2'b00, OP_STORE};
      5'b01_000: dec_instr = {{7{c[12]}}, c[6:2], c[11:7], 3'b000, c[11:7], OP_IMM};
      5'b01_001, 5'b01_101:
        dec_instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], {9{c[12]}},
                     c[15] ? 5'd0 : 5'd1, OP_JAL};
      5'b01_010: dec_instr = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, c[11:7], OP_IMM};
      5'b01_011: begin
        dec_ill = ({c[12], c[6:2]} == 6'h0);
        if (c[11:7] == 5'd2)
          dec_instr = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, OP_IMM};
        else
          dec_instr = {{15{c[12]}}, c[6:2], c[11:7], OP_LUI};
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: begin
            dec_instr = {7'b0, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
            dec_ill   = c[12];
          end
          2'b01: begin
            dec_instr = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
            dec_ill   = c[12];
          end
          2'b10: dec_instr = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, OP_IMM};
          default: begin
            dec_ill = c[12];
            case (c[6:5])
              2'b00:   dec_instr = {7'b0100000, rs2p, rs1p, 3'b000, rs1p, OP_REG};
              2'b01:   dec_instr = {7'b0000000, rs2p, rs1p, 3'b100, rs1p, OP_REG};
              2'b10:   dec_instr = {7'b0000000, rs2p, rs1p, 3'b110, rs1p, OP_REG};
              default: dec_instr = {7'b0000000, rs2p, rs1p, 3'b111, rs1p, OP_REG};
            endcase
          end
        endcase
      end
      5'b01_110, 5'b01_111:
        dec_instr = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, {2'b00, c[13]},
                     c[11:10], c[4:3], c[12], OP_BR};
      5'b10_000: begin
        dec_instr = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], OP_IMM};
        dec_ill   = c[12];
      end
      5'b10_010: begin
        dec_instr = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], OP_LOAD};
        dec_ill   = (c[11:7] == 5'd0);
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (c[6:2] == 5'd0) begin
            dec_instr = {12'b0, c[11:7], 3'b000, 5'd0, OP_JALR};
            dec_ill   = (c[11:7] == 5'd0);
          end else begin
            dec_instr = {7'b0, c[6:2], 5'd0, 3'b000, c[11:7], OP_REG};
          end
        end else if (c[6:2] == 5'd0) begin
          dec_instr = (c[11:7] == 5'd0) ? 32'h0010_0073 : {12'b0, c[11:7], 3'b000, 5'd1, OP_JALR};
        end else begin
          dec_instr = {7'b0, c[6:2], c[11:7], 3'b000, c[11:7], OP_REG};
        end
      end
      5'b10_110: dec_instr = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, OP_STORE};
      default:   dec_ill = 1'b1;
    endcase
  end

  // Next-state: flush wins; otherwise push and pop apply together.
  always_comb begin
    buf_d    = buf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    state_d  = state_q;
    push_n   = '0;
    pop_n    = '0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = flush_pc_i & ~32'h1;
      state_d  = flush_pc_i[1] ? ST_SKIP : ST_RUN;
    end else begin
      if (push) begin
        if (state_q == ST_SKIP) begin
          buf_d[wr_ptr_q] = {fetch_err_i, fetch_data_i[31:16]};
          wr_ptr_d        = ptr_inc(wr_ptr_q);
          push_n          = CNT_W'(1);
          state_d         = ST_RUN;
        end else begin
          buf_d[wr_ptr_q]          = {fetch_err_i, fetch_data_i[15:0]};
          buf_d[ptr_inc(wr_ptr_q)] = {fetch_err_i, fetch_data_i[31:16]};
          wr_ptr_d                 = ptr_inc(ptr_inc(wr_ptr_q));
          push_n                   = CNT_W'(2);
        end
      end
      if (pop) begin
        pc_d = pc_q + (comp ? 32'd2 : 32'd4);
        if (err || comp) begin
          pop_n    = CNT_W'(1);
          rd_ptr_d = rd_nxt;
          if (err) state_d = ST_ERR;
        end else begin
          pop_n    = CNT_W'(2);
          rd_ptr_d = ptr_inc(rd_nxt);
        end
      end
      count_d = count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < HW_DEPTH; i++) buf_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_VECTOR;
      state_q  <= ST_RUN;
    end else begin
      for (int unsigned i = 0; i < HW_DEPTH; i++) buf_q[i] <= buf_d[i];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench for fetch_align_buffer: directed fetch words, expected
// instructions queued up front and checked by an independent monitor.
module tb_fetch_align_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic        fetch_err_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        is_compressed_o;
  logic        illegal_o;
  logic        fetch_err_o;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        ill;
    logic        err;
    logic        chk_instr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_align_buffer #(.HW_DEPTH(4), .RESET_VECTOR(32'h8000_0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_data_i(fetch_data_i), .fetch_err_i(fetch_err_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .is_compressed_o(is_compressed_o),
    .illegal_o(illegal_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [31:0] instr, input logic [31:0] pc, input logic comp,
                          input logic ill, input logic err, input logic chk_instr);
    exp_t e;
    e.instr = instr; e.pc = pc; e.comp = comp; e.ill = ill; e.err = err; e.chk_instr = chk_instr;
    sb.push_back(e);
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic e);
    int n = 0;
    while (!fetch_ready_o && n < 50) begin
      cycle(1);
      n++;
    end
    if (!fetch_ready_o) begin
      chk("push_timeout", 32'(fetch_ready_o), 32'd1);
      return;
    end
    fetch_valid_i = 1'b1;
    fetch_data_i  = d;
    fetch_err_i   = e;
    cycle(1);
    fetch_valid_i = 1'b0;
    fetch_err_i   = 1'b0;
  endtask

  task automatic flush_to(input logic [31:0] pc);
    flush_i    = 1'b1;
    flush_pc_i = pc;
    cycle(1);
    flush_i    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      cycle(1);
      k++;
    end
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && instr_valid_o && instr_ready_i && !flush_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_instr_pc", instr_pc_o, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_instr) chk("instr", instr_o, mon_e.instr);
        chk("pc", instr_pc_o, mon_e.pc);
        chk("is_compressed", 32'(is_compressed_o), 32'(mon_e.comp));
        chk("illegal", 32'(illegal_o), 32'(mon_e.ill));
        chk("fetch_err", 32'(fetch_err_o), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; flush_pc_i = '0; fetch_valid_i = 1'b0;
    fetch_data_i = '0; fetch_err_i = 1'b0; instr_ready_i = 1'b1;

    // Reset state
    #12;
    chk("rst_ready", 32'(fetch_ready_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    cycle(2);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", 32'(fetch_ready_o), 32'd1);
    chk("post_rst_valid", 32'(instr_valid_o), 32'd0);
    cycle(1);

    // Sequential mix: c.li a0,4 / c.li a1,0, ecall, then a plain 32-bit word
    exp_push(32'h0040_0513, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_push(32'h0000_0593, 32'h8000_0002, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_push(32'h0000_0073, 32'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_push(32'h4581_0513, 32'h8000_0008, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch_valid_i = 1'b1; fetch_data_i = 32'h4581_4511;
    #1;
    chk("no_comb_path", 32'(instr_valid_o), 32'd0);
    cycle(1);
    fetch_valid_i = 1'b0;
    chk("latency_n1", 32'(instr_valid_o), 32'd1);
    push_word(32'h0000_0073, 1'b0);
    push_word(32'h4581_0513, 1'b0);
    wait_drain("drain_seq");

    // Misaligned 32-bit entry at a halfword target
    flush_to(32'h8000_0102);
    chk("valid_after_flush", 32'(instr_valid_o), 32'd0);
    push_word(32'h0513_DEAD, 1'b0);
    chk("half_wait_valid", 32'(instr_valid_o), 32'd0);
    exp_push(32'h0040_0513, 32'h8000_0102, 1'b0, 1'b0, 1'b0, 1'b1);
    push_word(32'hBEEF_0040, 1'b0);
    wait_drain("drain_misaligned");

    // Backpressure and full buffer
    flush_to(32'h8000_0300);
    instr_ready_i = 1'b0;
    exp_push(32'h0040_0513, 32'h8000_0300, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_push(32'h0000_0593, 32'h8000_0302, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_push(32'h00A0_0093, 32'h8000_0304, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_push(32'h00B0_0113, 32'h8000_0308, 1'b0, 1'b0, 1'b0, 1'b1);
    push_word(32'h4581_4511, 1'b0);
    chk("ready_at_2", 32'(fetch_ready_o), 32'd1);
    push_word(32'h00A0_0093, 1'b0);
    chk("ready_at_4", 32'(fetch_ready_o), 32'd0);
    cycle(3);
    chk("stall_instr", instr_o, 32'h0040_0513);
    chk("stall_pc", instr_pc_o, 32'h8000_0300);
    chk("stall_valid", 32'(instr_valid_o), 32'd1);
    instr_ready_i = 1'b1;
    cycle(1);
    instr_ready_i = 1'b0;
    chk("ready_at_3", 32'(fetch_ready_o), 32'd0);
    chk("stall_instr2", instr_o, 32'h0000_0593);
    instr_ready_i = 1'b1;
    cycle(1);
    instr_ready_i = 1'b0;
    chk("ready_at_2b", 32'(fetch_ready_o), 32'd1);
    instr_ready_i = 1'b1;
    push_word(32'h00B0_0113, 1'b0);
    chk("pushpop_pc", instr_pc_o, 32'h8000_0308);
    wait_drain("drain_backpressure");

    // Illegal compressed encodings then a faulted word
    flush_to(32'h8000_0400);
    exp_push(32'h0, 32'h8000_0400, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_push(32'h0, 32'h8000_0402, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_push(32'h0, 32'h8000_0404, 1'b0, 1'b0, 1'b1, 1'b0);
    push_word(32'h0000_0000, 1'b0);
    push_word(32'h0000_0013, 1'b1);
    wait_drain("drain_err");
    cycle(2);
    chk("err_hold_valid", 32'(instr_valid_o), 32'd0);
    chk("err_hold_ready", 32'(fetch_ready_o), 32'd0);

    // Flush colliding with a push and a pop
    flush_to(32'h8000_0500);
    instr_ready_i = 1'b0;
    push_word(32'h0000_0073, 1'b0);
    instr_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_data_i = 32'h0001_0001;
    flush_i = 1'b1; flush_pc_i = 32'h8000_0200;
    cycle(1);
    flush_i = 1'b0; fetch_valid_i = 1'b0;
    chk("collide_valid", 32'(instr_valid_o), 32'd0);
    chk("collide_ready", 32'(fetch_ready_o), 32'd1);
    exp_push(32'h0040_0513, 32'h8000_0200, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_push(32'h0000_0593, 32'h8000_0202, 1'b1, 1'b0, 1'b0, 1'b1);
    push_word(32'h4581_4511, 1'b0);
    wait_drain("drain_collide");

    // Asynchronous reset mid-stream
    flush_to(32'h8000_0600);
    instr_ready_i = 1'b0;
    push_word(32'h4581_4511, 1'b0);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_flags", 32'({instr_valid_o, is_compressed_o, illegal_o, fetch_err_o, fetch_ready_o}), 32'd0);
    chk("arst_instr", instr_o, 32'd0);
    chk("arst_pc", instr_pc_o, 32'd0);
    cycle(2);
    #3;
    rst_ni = 1'b1;
    cycle(1);
    instr_ready_i = 1'b1;
    exp_push(32'h0040_0513, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_push(32'h0000_0013, 32'h8000_0002, 1'b1, 1'b0, 1'b0, 1'b1);
    push_word(32'h0001_4511, 1'b0);
    wait_drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
